// File: rtl/conv3x3_stream.sv
//------------------------------------------------------------------------------
// Module   : conv3x3_stream
// Purpose  : Joins three row streams (rows y-1, y, y+1), applies a runtime
//            selectable 3x3 kernel (bypass / Gaussian / Sobel) across beat
//            boundaries with border replication and emits one filtered row.
// Ports    : i_clk, i_rst                  clock, synchronous active-high reset
//            i_lineN_data_valid/_data      row y-1 / y / y+1 input beats
//            o_lineN_data_ack              common join acknowledge
//            o_data_valid/o_data/i_data_ack filtered output beat handshake
//            i_mode                        0/3 bypass, 1 Gaussian, 2 Sobel
//            i_line_beats                  beats per line (0 behaves as 1)
//            o_busy                        beat held or output pending
// Options  : CONV3X3_SOBEL_EN - when defined mode 2 computes Sobel,
//            otherwise the Sobel datapath is absent and mode 2 is bypass.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module conv3x3_stream #(
    parameter int PIX_W = 8,
    parameter int PIX_N = 8,
    parameter int LB_W  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_line1_data_valid,
    input  logic                   i_line2_data_valid,
    input  logic                   i_line3_data_valid,
    input  logic [PIX_W*PIX_N-1:0] i_line1_data,
    input  logic [PIX_W*PIX_N-1:0] i_line2_data,
    input  logic [PIX_W*PIX_N-1:0] i_line3_data,
    output logic                   o_line1_data_ack,
    output logic                   o_line2_data_ack,
    output logic                   o_line3_data_ack,
    output logic                   o_data_valid,
    output logic [PIX_W*PIX_N-1:0] o_data,
    input  logic                   i_data_ack,
    input  logic [1:0]             i_mode,
    input  logic [LB_W-1:0]        i_line_beats,
    output logic                   o_busy
);

    localparam int DATA_W = PIX_W * PIX_N;
    localparam int ACC_W  = PIX_W + 4;

    localparam logic [1:0]       c_EMPTY   = 2'd0;  // nothing held
    localparam logic [1:0]       c_HOLD    = 2'd1;  // C held, more beats follow in this line
    localparam logic [1:0]       c_LAST    = 2'd2;  // C held and is the last beat of its line
    localparam logic [PIX_W-1:0] c_PIX_MAX = '1;

    logic [1:0]        r_state_q, w_state_d;
    logic [LB_W-1:0]   r_cnt_q, w_cnt_d;
    logic [LB_W-1:0]   r_len_q, w_len_d;
    logic [1:0]        r_mode_q, w_mode_d;
    logic              r_first_q, w_first_d;
    logic [DATA_W-1:0] r_c_q     [3];
    logic [DATA_W-1:0] w_c_d     [3];
    logic [PIX_W-1:0]  r_plast_q [3];
    logic [PIX_W-1:0]  w_plast_d [3];
    logic              r_ovalid_q, w_ovalid_d;
    logic [DATA_W-1:0] r_odata_q, w_odata_d;

    logic [DATA_W-1:0] w_row [3];
    logic [PIX_W-1:0]  w_win [3][PIX_N+2];
    logic [DATA_W-1:0] w_result;
    logic              w_adv, w_accept, w_emit, w_is_last;
    logic [LB_W-1:0]   w_len_in, w_len_cur;

    function automatic logic [PIX_W-1:0] f_gauss(
        input logic [PIX_W-1:0] tl, tc, tr, ml, mc, mr, bl, bc, br);
        logic [ACC_W-1:0] s;
        s = ACC_W'(tl) + ACC_W'(tr) + ACC_W'(bl) + ACC_W'(br)
          + (ACC_W'(tc) << 1) + (ACC_W'(ml) << 1) + (ACC_W'(mr) << 1) + (ACC_W'(bc) << 1)
          + (ACC_W'(mc) << 2) + ACC_W'(8);
        return PIX_W'(s >> 4);
    endfunction

`ifdef CONV3X3_SOBEL_EN
    function automatic logic [PIX_W-1:0] f_sobel(
        input logic [PIX_W-1:0] tl, tc, tr, ml, mr, bl, bc, br);
        logic [ACC_W-1:0] gx, gy, ax, ay, mag;
        // Two's-complement differences; magnitudes stay below 2^(PIX_W+3).
        gx  = (ACC_W'(tr) + (ACC_W'(mr) << 1) + ACC_W'(br))
            - (ACC_W'(tl) + (ACC_W'(ml) << 1) + ACC_W'(bl));
        gy  = (ACC_W'(bl) + (ACC_W'(bc) << 1) + ACC_W'(br))
            - (ACC_W'(tl) + (ACC_W'(tc) << 1) + ACC_W'(tr));
        ax  = gx[ACC_W-1] ? (~gx + ACC_W'(1)) : gx;
        ay  = gy[ACC_W-1] ? (~gy + ACC_W'(1)) : gy;
        mag = ax + ay;
        return (mag > ACC_W'(c_PIX_MAX)) ? c_PIX_MAX : PIX_W'(mag);
    endfunction
`endif

    assign w_row[0] = i_line1_data;
    assign w_row[1] = i_line2_data;
    assign w_row[2] = i_line3_data;

    // Output register is free if empty or being drained this cycle.
    assign w_adv     = !r_ovalid_q || i_data_ack;
    assign w_accept  = i_line1_data_valid && i_line2_data_valid && i_line3_data_valid
                       && w_adv && !i_rst;
    // Line length applies from beat 0, so beat 0 uses the live input value.
    assign w_len_in  = (i_line_beats == '0) ? LB_W'(1) : i_line_beats;
    assign w_len_cur = (r_cnt_q == '0) ? w_len_in : r_len_q;
    assign w_is_last = (r_cnt_q == (w_len_cur - LB_W'(1)));

    // FSM: state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q <= c_EMPTY;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_EMPTY, c_HOLD: begin
                if (w_accept) w_state_d = w_is_last ? c_LAST : c_HOLD;
            end
            c_LAST: begin
                // Flush happens on any adv cycle; a new line may start alongside.
                if (w_accept)   w_state_d = w_is_last ? c_LAST : c_HOLD;
                else if (w_adv) w_state_d = c_EMPTY;
            end
            default: w_state_d = c_EMPTY;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_emit           = ((r_state_q == c_HOLD) && w_accept) || ((r_state_q == c_LAST) && w_adv);
        o_line1_data_ack = w_accept;
        o_line2_data_ack = w_accept;
        o_line3_data_ack = w_accept;
        o_busy           = (r_state_q != c_EMPTY) || r_ovalid_q;
    end

    // 3 x (PIX_N+2) window around C: replicated or carried left edge,
    // right edge from the incoming beat or replicated at end of line.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < PIX_N; i++) begin
                w_win[r][i+1] = r_c_q[r][i*PIX_W +: PIX_W];
            end
            w_win[r][0]       = r_first_q ? r_c_q[r][0 +: PIX_W] : r_plast_q[r];
            w_win[r][PIX_N+1] = (r_state_q == c_LAST) ? r_c_q[r][DATA_W-PIX_W +: PIX_W]
                                                      : w_row[r][0 +: PIX_W];
        end
    end

    always_comb begin
        w_result = '0;
        for (int i = 0; i < PIX_N; i++) begin
            case (r_mode_q)
                2'd1: w_result[i*PIX_W +: PIX_W] = f_gauss(
                          w_win[0][i], w_win[0][i+1], w_win[0][i+2],
                          w_win[1][i], w_win[1][i+1], w_win[1][i+2],
                          w_win[2][i], w_win[2][i+1], w_win[2][i+2]);
`ifdef CONV3X3_SOBEL_EN
                2'd2: w_result[i*PIX_W +: PIX_W] = f_sobel(
                          w_win[0][i], w_win[0][i+1], w_win[0][i+2],
                          w_win[1][i],                w_win[1][i+2],
                          w_win[2][i], w_win[2][i+1], w_win[2][i+2]);
`endif
                default: w_result[i*PIX_W +: PIX_W] = w_win[1][i+1];
            endcase
        end
    end

    // Datapath next-state
    always_comb begin
        w_cnt_d    = r_cnt_q;
        w_len_d    = r_len_q;
        w_mode_d   = r_mode_q;
        w_first_d  = r_first_q;
        w_c_d      = r_c_q;
        w_plast_d  = r_plast_q;
        w_ovalid_d = r_ovalid_q;
        w_odata_d  = r_odata_q;
        if (w_accept) begin
            for (int r = 0; r < 3; r++) begin
                w_c_d[r]     = w_row[r];
                w_plast_d[r] = r_c_q[r][DATA_W-PIX_W +: PIX_W];
            end
            w_first_d = (r_cnt_q == '0);
            w_cnt_d   = w_is_last ? '0 : (r_cnt_q + LB_W'(1));
            if (r_cnt_q == '0) begin
                w_len_d  = w_len_in;
                w_mode_d = i_mode;
            end
        end
        if (w_emit) begin
            w_ovalid_d = 1'b1;
            w_odata_d  = w_result;
        end else if (i_data_ack) begin
            w_ovalid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt_q    <= '0;
            r_len_q    <= LB_W'(1);
            r_mode_q   <= 2'd0;
            r_first_q  <= 1'b1;
            r_ovalid_q <= 1'b0;
            r_odata_q  <= '0;
            for (int r = 0; r < 3; r++) begin
                r_c_q[r]     <= '0;
                r_plast_q[r] <= '0;
            end
        end else begin
            r_cnt_q    <= w_cnt_d;
            r_len_q    <= w_len_d;
            r_mode_q   <= w_mode_d;
            r_first_q  <= w_first_d;
            r_ovalid_q <= w_ovalid_d;
            r_odata_q  <= w_odata_d;
            r_c_q      <= w_c_d;
            r_plast_q  <= w_plast_d;
        end
    end

    assign o_data_valid = r_ovalid_q;
    assign o_data       = r_odata_q;

endmodule

`default_nettype wire

// File: tb/tb_conv3x3_stream.sv
//------------------------------------------------------------------------------
// Module   : tb_conv3x3_stream
// Purpose  : Self-checking bench for conv3x3_stream. A line-level image model
//            filters each complete line and a scoreboard matches DUT beats;
//            literal expectations pin the model on directed vectors.
// Options  : CONV3X3_SOBEL_EN selects the Sobel expectation for mode 2.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_conv3x3_stream;

    localparam int PIX_W  = 8;
    localparam int PIX_N  = 8;
    localparam int LB_W   = 16;
    localparam int DATA_W = PIX_W * PIX_N;

    logic              clk = 1'b0;
    logic              rst;
    logic              v1, v2, v3;
    logic [DATA_W-1:0] d1, d2, d3;
    logic              ack1, ack2, ack3;
    logic              o_data_valid;
    logic [DATA_W-1:0] o_data;
    logic              i_data_ack;
    logic [1:0]        mode;
    logic [LB_W-1:0]   lb;
    logic              o_busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    conv3x3_stream #(.PIX_W(PIX_W), .PIX_N(PIX_N), .LB_W(LB_W)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_line1_data_valid (v1),
        .i_line2_data_valid (v2),
        .i_line3_data_valid (v3),
        .i_line1_data       (d1),
        .i_line2_data       (d2),
        .i_line3_data       (d3),
        .o_line1_data_ack   (ack1),
        .o_line2_data_ack   (ack2),
        .o_line3_data_ack   (ack3),
        .o_data_valid       (o_data_valid),
        .o_data             (o_data),
        .i_data_ack         (i_data_ack),
        .i_mode             (mode),
        .i_line_beats       (lb),
        .o_busy             (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // ---------------- line-level model ----------------
    int                img [3][0:127];
    int                m_cnt = 0, m_len = 1, m_mode = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] obs_q[$];
    logic [DATA_W-1:0] obs_log[$];

    function automatic void model_line();
        int M;
        M = m_len * PIX_N;
        for (int b = 0; b < m_len; b++) begin
            logic [DATA_W-1:0] o;
            o = '0;
            for (int i = 0; i < PIX_N; i++) begin
                int x, l, r, v, gx, gy;
                x = b * PIX_N + i;
                l = (x == 0) ? 0 : x - 1;
                r = (x == M - 1) ? M - 1 : x + 1;
                v = img[1][x];
                if (m_mode == 1) begin
                    v = (img[0][l] + 2*img[0][x] + img[0][r]
                       + 2*img[1][l] + 4*img[1][x] + 2*img[1][r]
                       + img[2][l] + 2*img[2][x] + img[2][r] + 8) / 16;
                end
`ifdef CONV3X3_SOBEL_EN
                if (m_mode == 2) begin
                    gx = (img[0][r] + 2*img[1][r] + img[2][r]) - (img[0][l] + 2*img[1][l] + img[2][l]);
                    gy = (img[2][l] + 2*img[2][x] + img[2][r]) - (img[0][l] + 2*img[0][x] + img[0][r]);
                    v  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                    if (v > (1 << PIX_W) - 1) v = (1 << PIX_W) - 1;
                end
`else
                gx = 0; gy = 0;
`endif
                o[i*PIX_W +: PIX_W] = PIX_W'(v);
            end
            exp_q.push_back(o);
        end
    endfunction

    function automatic void model_accept(input logic [DATA_W-1:0] a, b, c,
                                         input logic [1:0] md, input logic [LB_W-1:0] ln);
        if (m_cnt == 0) begin
            m_len  = (ln == 0) ? 1 : int'(ln);
            m_mode = int'(md);
        end
        for (int i = 0; i < PIX_N; i++) begin
            img[0][m_cnt*PIX_N + i] = int'(a[i*PIX_W +: PIX_W]);
            img[1][m_cnt*PIX_N + i] = int'(b[i*PIX_W +: PIX_W]);
            img[2][m_cnt*PIX_N + i] = int'(c[i*PIX_W +: PIX_W]);
        end
        m_cnt++;
        if (m_cnt == m_len) begin
            model_line();
            m_cnt = 0;
        end
    endfunction

    // ---------------- monitor / compare process ----------------
    logic              prev_stall = 1'b0;
    logic              prev_valid = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;
    int                rise_cyc   = 0;
    int                n_stall    = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_cnt = 0;
            exp_q.delete();
            obs_q.delete();
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_held", 64'(o_data_valid), 64'd1);
                chk("stall_data_held", o_data, prev_data);
            end
            if (o_data_valid && !i_data_ack) begin
                n_stall++;
                chk("stall_acks_low", 64'({ack1, ack2, ack3}), 64'd0);
            end
            if (o_data_valid && !prev_valid) rise_cyc = cyc;
            if (o_data_valid && i_data_ack) begin
                obs_q.push_back(o_data);
                obs_log.push_back(o_data);
            end
            if (ack1 && v1 && v2 && v3) model_accept(d1, d2, d3, mode, lb);
            while (obs_q.size() != 0 && exp_q.size() != 0) begin
                chk("scoreboard", obs_q.pop_front(), exp_q.pop_front());
            end
            prev_stall = o_data_valid && !i_data_ack;
            prev_valid = o_data_valid;
            prev_data  = o_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic put_beat(input logic [DATA_W-1:0] a, b, c, output int t_acc);
        int n;
        n  = 0;
        v1 = 1'b1; v2 = 1'b1; v3 = 1'b1;
        d1 = a;    d2 = b;    d3 = c;
        @(negedge clk);
        while (!ack1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("accept_timeout", 64'(ack1), 64'd1);
        t_acc = cyc;
        @(posedge clk); #1;
        v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || obs_q.size() != 0 || o_data_valid || o_busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(n >= 300), 64'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int t0, t, base, st0;
        logic [DATA_W-1:0] z;
        z  = '0;
        rst = 1'b1; v1 = 0; v2 = 0; v3 = 0; d1 = '0; d2 = '0; d3 = '0;
        i_data_ack = 1'b1; mode = 2'd0; lb = 16'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 64'(o_data_valid), 64'd0);
        chk("reset_data", o_data, 64'd0);
        chk("reset_busy", 64'(o_busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_acks", 64'({ack1, ack2, ack3}), 64'd0);
        @(posedge clk); #1;

        // Bypass, 2-beat line
        base = obs_log.size();
        mode = 2'd0; lb = 16'd2;
        put_beat(64'hFFFF_FFFF_FFFF_FFFF, 64'h0807_0605_0403_0201, 64'h5555_5555_5555_5555, t0);
        put_beat(64'hFFFF_FFFF_FFFF_FFFF, 64'h100F_0E0D_0C0B_0A09, 64'h5555_5555_5555_5555, t);
        drain();
        chk("bypass_latency", 64'(rise_cyc - t0), 64'd2);
        chk("bypass_beat0", obs_log[base],   64'h0807_0605_0403_0201);
        chk("bypass_beat1", obs_log[base+1], 64'h100F_0E0D_0C0B_0A09);

        // Gaussian flat field and impulse, single-beat lines
        base = obs_log.size();
        mode = 2'd1; lb = 16'd1;
        put_beat({8{8'd100}}, {8{8'd100}}, {8{8'd100}}, t);
        put_beat(z, 64'h0000_0000_FF00_0000, z, t);
        drain();
        chk("gauss_flat", obs_log[base], {8{8'd100}});
        chk("gauss_impulse", obs_log[base+1], 64'h0000_0020_4020_0000);

        // Sobel vertical edge, single-beat line
        base = obs_log.size();
        mode = 2'd2; lb = 16'd1;
        put_beat(64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, t);
        drain();
`ifdef CONV3X3_SOBEL_EN
        chk("sobel_edge", obs_log[base], 64'h0000_00FF_FF00_0000);
`else
        chk("mode2_bypass", obs_log[base], 64'hFFFF_FFFF_0000_0000);
`endif

        // Line length 0 behaves as 1
        base = obs_log.size();
        mode = 2'd3; lb = 16'd0;
        put_beat(64'h1111_1111_1111_1111, 64'h0123_4567_89AB_CDEF, z, t);
        drain();
        chk("len0_bypass", obs_log[base], 64'h0123_4567_89AB_CDEF);

        // Cross-beat continuity, Gaussian 2-beat line
        base = obs_log.size();
        mode = 2'd1; lb = 16'd2;
        put_beat(z, z, z, t);
        put_beat(z, 64'h0000_0000_0000_00A0, z, t);
        drain();
        chk("cross_beat0", obs_log[base],   64'h1400_0000_0000_0000);
        chk("cross_beat1", obs_log[base+1], 64'h0000_0000_0000_1428);

        // Backpressure, 4-beat Gaussian line with mid-line config change
        base = obs_log.size();
        st0  = n_stall;
        mode = 2'd1; lb = 16'd4;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    logic [DATA_W-1:0] a, b, c;
                    a = 64'h1122_3344_5566_7788 ^ {8{8'(k * 29)}};
                    b = 64'h90A0_B0C0_D0E0_F000 ^ {8{8'(k * 53 + 7)}};
                    c = 64'h0F1E_2D3C_4B5A_6978 ^ {8{8'(k * 17 + 3)}};
                    put_beat(a, b, c, t);
                    if (k == 1) begin
                        mode = 2'd0;
                        lb   = 16'd2;
                    end
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1 i_data_ack = 1'b0;
                repeat (5) @(posedge clk);
                #1 i_data_ack = 1'b1;
            end
        join
        drain();
        chk("bp_count", 64'(obs_log.size() - base), 64'd4);
        chk("bp_stall_cycles", 64'(n_stall - st0), 64'd5);

        // Reset mid-line, then a full 3-beat line
        mode = 2'd1; lb = 16'd3;
        put_beat({8{8'hFF}}, {8{8'hFF}}, {8{8'hFF}}, t);
        @(negedge clk);
        chk("pre_reset_busy", 64'(o_busy), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_valid", 64'(o_data_valid), 64'd0);
        chk("post_reset_busy", 64'(o_busy), 64'd0);
        @(posedge clk); #1;
        base = obs_log.size();
        put_beat(z, 64'h0000_0000_0000_00A0, z, t);
        put_beat(z, z, z, t);
        put_beat(z, 64'h0700_0000_0000_0000, z, t);
        drain();
        chk("reset_line_count", 64'(obs_log.size() - base), 64'd3);
        chk("reset_left_edge", obs_log[base], 64'h0000_0000_0000_143C);
        chk("leftover_expected", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
